wdrr_indirect_regs: RTL and testbench

WDRR_INDIRECT_REGS -- requirements
Module: wdrr_indirect_regs

---
 rtl/wdrr_regs_pkg.sv | 24 ++
 rtl/wdrr_reg_bank.sv | 51 +++++
 rtl/wdrr_indirect_regs.sv | 159 +++++++++++++++
 tb/tb_wdrr_indirect_regs.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdrr_regs_pkg.sv
// Shared constants and types for the WDRR indirect register block.
package wdrr_regs_pkg;

  // Block-local register offsets
  localparam int OFF_WR_IDX  = 0;
  localparam int OFF_RD_IDX  = 1;
  localparam int OFF_WR_DATA = 2;
  localparam int OFF_RD_DATA = 3;
  localparam int OFF_STATUS  = 4;
  localparam int OFF_ID      = 5;

  // Pattern returned by reads of unused offsets
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // STATUS bit holding the sticky access error
  localparam int ERR_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/wdrr_reg_bank.sv
// Per-queue configuration file: flat word storage, single write port,
// one-cycle per-queue write strobe and a readback word at the write index.
module wdrr_reg_bank
  import wdrr_regs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_QUEUES = 64,
  parameter int WR_PER_Q   = 4,
  parameter int IDX_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 we_i,
  input  logic [IDX_W-1:0]                     idx_i,
  input  logic [DATA_W-1:0]                    data_i,
  output logic [DATA_W*NUM_QUEUES*WR_PER_Q-1:0] wr_regs_o,
  output logic [NUM_QUEUES-1:0]                wr_strobe_o,
  output logic [DATA_W-1:0]                    rd_word_o
);

  localparam int TOTAL_W = DATA_W * NUM_QUEUES * WR_PER_Q;
  localparam int BASE_W  = $clog2(TOTAL_W);
  localparam int QSEL_W  = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  logic [TOTAL_W-1:0]    file_q;
  logic [NUM_QUEUES-1:0] strobe_q;
  logic [BASE_W-1:0]     base;
  logic [QSEL_W-1:0]     q_sel;

  assign base  = BASE_W'(int'(idx_i) * DATA_W);
  assign q_sel = QSEL_W'(int'(idx_i) / WR_PER_Q);

  // Store the written word; the strobe is high only in the cycle after a write
  always_ff @(posedge clk) begin
    if (reset) begin
      file_q   <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      if (we_i) begin
        file_q[base +: DATA_W] <= data_i;
        strobe_q[q_sel]        <= 1'b1;
      end
    end
  end

  assign wr_regs_o   = file_q;
  assign wr_strobe_o = strobe_q;
  assign rd_word_o   = file_q[base +: DATA_W];

endmodule

// File: rtl/wdrr_indirect_regs.sv
// Indirect register window onto the WDRR scheduler's per-queue config and
// status files. Optional build macro: WDRR_REGS_AUTOINC_EN (index
// auto-increment after each data access, reported in ID bit 31).
module wdrr_indirect_regs
  import wdrr_regs_pkg::*;
#(
  parameter int                            DATA_W     = 32,
  parameter int                            ADDR_W     = 23,
  parameter int                            REG_ADDR_W = 6,
  parameter logic [ADDR_W-REG_ADDR_W-1:0]  BLOCK_ADDR = 17'h00020,
  parameter int                            NUM_QUEUES = 64,
  parameter int                            WR_PER_Q   = 4,
  parameter int                            RD_PER_Q   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reg_req_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [ADDR_W-1:0]                     reg_addr_in,
  input  logic [DATA_W-1:0]                     reg_wr_data,
  output logic                                  reg_ack_out,
  output logic [DATA_W-1:0]                     reg_rd_data,
  output logic [DATA_W*NUM_QUEUES*WR_PER_Q-1:0] wr_regs,
  output logic [NUM_QUEUES-1:0]                 wr_strobe,
  input  logic [DATA_W*NUM_QUEUES*RD_PER_Q-1:0] rd_regs
);

  localparam int NWR  = NUM_QUEUES * WR_PER_Q;
  localparam int NRD  = NUM_QUEUES * RD_PER_Q;
  localparam int WI_W = $clog2(NWR);
  localparam int RI_W = $clog2(NRD);
  localparam int RB_W = $clog2(DATA_W * NRD);

`ifdef WDRR_REGS_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam logic [31:0] ID_WORD = {AUTOINC, NUM_QUEUES[14:0], WR_PER_Q[7:0], RD_PER_Q[7:0]};

  state_e                  state_q, state_d;
  logic [WI_W-1:0]         wr_idx_q, wr_idx_d;
  logic [RI_W-1:0]         rd_idx_q, rd_idx_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic [REG_ADDR_W-1:0]   off;
  logic                    hit, accept, is_rd, off_known, err_set, err_clr, bank_we;
  logic [DATA_W-1:0]       rd_mux, bank_word, id_word, dead_word;
  logic [RB_W-1:0]         rd_base;

  // DEAD_BEEF replicated and ID zero-extended to the bus width
  for (genvar g = 0; g < DATA_W; g++) begin : g_fit
    assign dead_word[g] = DEAD_BEEF[g % 32];
    assign id_word[g]   = (g < 32) ? ID_WORD[g % 32] : 1'b0;
  end

  assign off       = reg_addr_in[REG_ADDR_W-1:0];
  assign hit       = (reg_addr_in[ADDR_W-1:REG_ADDR_W] == BLOCK_ADDR);
  assign is_rd     = reg_rd_wr_L_in;
  assign accept    = (state_q == S_IDLE) && reg_req_in && hit;
  assign off_known = (off <= REG_ADDR_W'(OFF_ID));
  assign rd_base   = RB_W'(int'(rd_idx_q) * DATA_W);

  // Read data selection by offset
  always_comb begin
    rd_mux = dead_word;
    case (off)
      REG_ADDR_W'(OFF_WR_IDX):  rd_mux = DATA_W'(wr_idx_q);
      REG_ADDR_W'(OFF_RD_IDX):  rd_mux = DATA_W'(rd_idx_q);
      REG_ADDR_W'(OFF_WR_DATA): rd_mux = bank_word;
      REG_ADDR_W'(OFF_RD_DATA): rd_mux = rd_regs[rd_base +: DATA_W];
      REG_ADDR_W'(OFF_STATUS): begin
        rd_mux          = '0;
        rd_mux[ERR_BIT] = err_q;
      end
      REG_ADDR_W'(OFF_ID):      rd_mux = id_word;
      default:                  rd_mux = dead_word;
    endcase
  end

  // Handshake FSM and the register side effects of an accepted request
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    rd_data_d = rd_data_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    bank_we   = 1'b0;

    case (state_q)
      S_IDLE:  if (accept) state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!reg_req_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      rd_data_d = is_rd ? rd_mux : '0;
      // STATUS is write-1-to-clear, so only RD_DATA and ID count as read-only
      err_set = !off_known ||
                (!is_rd && (off == REG_ADDR_W'(OFF_RD_DATA) || off == REG_ADDR_W'(OFF_ID)));
      err_clr = !is_rd && (off == REG_ADDR_W'(OFF_STATUS)) && reg_wr_data[ERR_BIT];
      if (!is_rd && off == REG_ADDR_W'(OFF_WR_IDX)) wr_idx_d = reg_wr_data[WI_W-1:0];
      if (!is_rd && off == REG_ADDR_W'(OFF_RD_IDX)) rd_idx_d = reg_wr_data[RI_W-1:0];
      if (!is_rd && off == REG_ADDR_W'(OFF_WR_DATA)) begin
        bank_we = 1'b1;
`ifdef WDRR_REGS_AUTOINC_EN
        wr_idx_d = (wr_idx_q == WI_W'(NWR - 1)) ? '0 : wr_idx_q + WI_W'(1);
`endif
      end
`ifdef WDRR_REGS_AUTOINC_EN
      if (is_rd && off == REG_ADDR_W'(OFF_RD_DATA))
        rd_idx_d = (rd_idx_q == RI_W'(NRD - 1)) ? '0 : rd_idx_q + RI_W'(1);
`endif
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign reg_ack_out = (state_q == S_ACK);
  assign reg_rd_data = rd_data_q;

  wdrr_reg_bank #(
    .DATA_W     (DATA_W),
    .NUM_QUEUES (NUM_QUEUES),
    .WR_PER_Q   (WR_PER_Q),
    .IDX_W      (WI_W)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .we_i        (bank_we),
    .idx_i       (wr_idx_q),
    .data_i      (reg_wr_data),
    .wr_regs_o   (wr_regs),
    .wr_strobe_o (wr_strobe),
    .rd_word_o   (bank_word)
  );

endmodule

// File: tb/tb_wdrr_indirect_regs.sv
// Bench for wdrr_indirect_regs: directed steps plus a randomized phase,
// checked against an array-based model of the register window.
module tb_wdrr_indirect_regs;

  localparam int DW  = 32;
  localparam int NQ  = 64;
  localparam int WPQ = 4;
  localparam int RPQ = 8;
  localparam int NEW = NQ * WPQ;
  localparam int NER = NQ * RPQ;
  localparam logic [16:0] TAG = 17'h00020;

`ifdef WDRR_REGS_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                reg_req_in;
  logic                reg_rd_wr_L_in;
  logic [22:0]         reg_addr_in;
  logic [DW-1:0]       reg_wr_data;
  logic                reg_ack_out;
  logic [DW-1:0]       reg_rd_data;
  logic [DW*NEW-1:0]   wr_regs;
  logic [NQ-1:0]       wr_strobe;
  logic [DW*NER-1:0]   rd_regs;

  always #5 clk = ~clk;

  wdrr_indirect_regs dut (
    .clk            (clk),
    .reset          (reset),
    .reg_req_in     (reg_req_in),
    .reg_rd_wr_L_in (reg_rd_wr_L_in),
    .reg_addr_in    (reg_addr_in),
    .reg_wr_data    (reg_wr_data),
    .reg_ack_out    (reg_ack_out),
    .reg_rd_data    (reg_rd_data),
    .wr_regs        (wr_regs),
    .wr_strobe      (wr_strobe),
    .rd_regs        (rd_regs)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] wr_m [NEW];
  logic [DW-1:0] rd_m [NER];
  int            m_wr_idx;
  int            m_rd_idx;
  bit            m_err;
  logic [31:0]   id_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_file(input string tag);
    int first;
    first = -1;
    for (int i = 0; i < NEW; i++)
      if (first < 0 && wr_regs[i*DW +: DW] !== wr_m[i]) first = i;
    total++;
    assert (first == -1) else begin
      bad++;
      $error("FAIL %s entry=%0d observed=%0h expected=%0h", tag, first,
             wr_regs[first*DW +: DW], wr_m[first]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NEW; i++) wr_m[i] = '0;
    m_wr_idx = 0;
    m_rd_idx = 0;
    m_err    = 1'b0;
  endtask

  // Expected effect of one accepted access
  task automatic model_op(input bit rd, input int off, input logic [31:0] wd,
                          output logic [31:0] exp_rd, output logic [NQ-1:0] exp_strb);
    exp_rd   = '0;
    exp_strb = '0;
    if (off >= 6) begin
      m_err = 1'b1;
      if (rd) exp_rd = 32'hDEAD_BEEF;
    end else if (rd) begin
      case (off)
        0: exp_rd = m_wr_idx;
        1: exp_rd = m_rd_idx;
        2: exp_rd = wr_m[m_wr_idx];
        3: begin
          exp_rd = rd_m[m_rd_idx];
          if (AUTOINC) m_rd_idx = (m_rd_idx + 1) % NER;
        end
        4: exp_rd = {31'd0, m_err};
        default: exp_rd = id_exp;
      endcase
    end else begin
      case (off)
        0: m_wr_idx = int'(wd % NEW);
        1: m_rd_idx = int'(wd % NER);
        2: begin
          wr_m[m_wr_idx] = wd;
          exp_strb = NQ'(1) << (m_wr_idx / WPQ);
          if (AUTOINC) m_wr_idx = (m_wr_idx + 1) % NEW;
        end
        4: if (wd % 2 == 1) m_err = 1'b0;
        default: m_err = 1'b1;
      endcase
    end
  endtask

  // One full handshake: request, wait (bounded) for ack, release, return to idle
  task automatic bus(input bit rd, input logic [16:0] tag, input int off, input logic [31:0] wd,
                     output int lat, output logic [31:0] rdat, output logic [NQ-1:0] strb,
                     output logic ack2, output logic [NQ-1:0] st2, output logic [31:0] hold);
    @(negedge clk);
    reg_req_in     = 1'b1;
    reg_rd_wr_L_in = rd;
    reg_addr_in    = {tag, 6'(off)};
    reg_wr_data    = wd;
    lat  = 0;
    rdat = 'x;
    strb = 'x;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (reg_ack_out) begin
        lat  = i;
        rdat = reg_rd_data;
        strb = wr_strobe;
      end
    end
    @(negedge clk);
    reg_req_in = 1'b0;
    @(posedge clk); #1;
    ack2 = reg_ack_out;
    st2  = wr_strobe;
    @(posedge clk); #1;
    hold = reg_rd_data;
  endtask

  task automatic op(input string tag, input bit rd, input int off, input logic [31:0] wd);
    int            lat;
    logic [31:0]   o_rd, e_rd, hold;
    logic [NQ-1:0] o_st, e_st, st2;
    logic          ack2;
    bus(rd, TAG, off, wd, lat, o_rd, o_st, ack2, st2, hold);
    model_op(rd, off, wd, e_rd, e_st);
    chk({tag, ".lat"}, lat, 1);
    chk({tag, ".data"}, o_rd, e_rd);
    chk({tag, ".strb"}, o_st, e_st);
    chk({tag, ".after"}, {ack2, st2}, '0);
    chk({tag, ".hold"}, hold, e_rd);
  endtask

  initial begin
    int            lat, acks, sel;
    logic [31:0]   rdat, hold, wd;
    logic [NQ-1:0] strb, st2;
    logic          ack2;

    id_exp = (32'(AUTOINC) << 31) | (32'(NQ) << 16) | (32'(WPQ) << 8) | 32'(RPQ);
    for (int i = 0; i < NER; i++) rd_m[i] = $urandom;
    rd_m[511] = 32'hCAFE_0001;
    for (int i = 0; i < NER; i++) rd_regs[i*DW +: DW] = rd_m[i];

    reset          = 1'b1;
    reg_req_in     = 1'b0;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in    = '0;
    reg_wr_data    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ack", reg_ack_out, 0);
    chk("rst.rdata", reg_rd_data, 0);
    chk("rst.strb", wr_strobe, 0);
    check_file("rst.file");
    @(negedge clk);
    reset = 1'b0;

    op("id", 1, 5, 0);
    op("wridx0", 1, 0, 0);
    op("rdidx0", 1, 1, 0);
    op("stat0", 1, 4, 0);

    op("w_idx5", 0, 0, 5);
    op("w_data5", 0, 2, 32'h1234_5678);
    chk("entry5", wr_regs[5*DW +: DW], 32'h1234_5678);
    check_file("f35");

    op("w_rdidx511", 0, 1, 511);
    op("r_cafe", 1, 3, 0);

    op("w_idx_upper", 0, 0, 32'hFFFF_FF03);
    op("r_idx_upper", 1, 0, 0);
    op("r_rdidx", 1, 1, 0);

    op("r_unused9", 1, 9, 0);
    op("stat_set", 1, 4, 0);
    op("stat_clr", 0, 4, 1);
    op("stat_clr_rd", 1, 4, 0);
    op("w_ro_id", 0, 5, 32'h1);
    op("w_stat0", 0, 4, 0);
    op("stat_kept", 1, 4, 0);
    op("clr2", 0, 4, 1);
    op("w_ro_rddata", 0, 3, 32'h77);
    op("stat_ro3", 1, 4, 0);
    op("clr3", 0, 4, 32'hFFFF_FFFF);
    op("w_unused40", 0, 40, 32'h99);
    op("stat_u40", 1, 4, 0);
    op("clr4", 0, 4, 1);

    bus(0, 17'h00021, 2, 32'hBAD0_BAD0, lat, rdat, strb, ack2, st2, hold);
    chk("miss_w.noack", lat, 0);
    chk("miss_w.noack2", ack2, 0);
    check_file("miss_w.file");
    bus(1, 17'h00021, 9, 0, lat, rdat, strb, ack2, st2, hold);
    chk("miss_r.noack", lat, 0);
    op("miss.stat", 1, 4, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      wd  = $urandom;
      case (sel)
        0: op("rnd.widx", 0, 0, wd);
        1, 2: op("rnd.wdata", 0, 2, wd);
        3: op("rnd.rdidx", 0, 1, wd);
        4: op("rnd.rdata", 1, 3, 0);
        5: op("rnd.ridx", 1, $urandom_range(0, 1), 0);
        6: op("rnd.stat", 1, 4, 0);
        7: op("rnd.wstat", 0, 4, wd);
        default: op("rnd.unused", $urandom_range(0, 1), $urandom_range(6, 63), wd);
      endcase
    end
    check_file("rnd.file");

    op("ai.widx", 0, 0, 255);
    op("ai.wA", 0, 2, 32'hA);
    op("ai.wB", 0, 2, 32'hB);
    op("ai.ridx", 1, 0, 0);
    chk("ai.entry255", wr_regs[255*DW +: DW], AUTOINC ? 32'hA : 32'hB);
    check_file("ai.file");

    op("r40.widx", 0, 0, 7);
    @(negedge clk);
    reg_req_in     = 1'b1;
    reg_rd_wr_L_in = 1'b0;
    reg_addr_in    = {TAG, 6'd2};
    reg_wr_data    = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("r40.ack", reg_ack_out, 1);
    chk("r40.strb", wr_strobe, NQ'(1) << 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("r40.rst_ack", reg_ack_out, 0);
    chk("r40.rst_rdata", reg_rd_data, 0);
    chk("r40.rst_strb", wr_strobe, 0);
    model_reset();
    check_file("r40.rst_file");
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (reg_ack_out) acks++;
    end
    chk("r40.one_ack", acks, 1);
    model_op(0, 2, 32'h5555_AAAA, rdat, strb);
    @(negedge clk);
    reg_req_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_file("r40.file");
    op("r40.ridx", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
